// File: rtl/ps2_key_decoder.sv
// PS/2 scan code set 2 decoder.
// Turns a stream of received bytes into make/break key events, held in a
// small first-word-fall-through FIFO. Device control bytes are reported as
// single-cycle pulses. Parity-error bytes are counted and abort any
// half-decoded prefix.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rcv_data,
    input  logic       rcv_vld,
    input  logic       rcv_parity_err,
    output logic       evt_vld,
    input  logic       evt_rdy,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_brk,
    output logic       ctl_vld,
    output logic [7:0] ctl_byte,
    output logic [7:0] err_cnt,
    output logic       ovf,
    input  logic       clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    // Bytes following E1 that belong to the pause sequence and are skipped.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        PAUSE
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [2:0] skip_cnt;
    logic [2:0] next_skip;

    logic       push_req;
    logic [7:0] push_code;
    logic       push_ext;
    logic       push_brk;
    logic       ctl_hit;

    // FIFO storage: {ext, brk, code} per entry.
    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             pop;
    logic             do_push;
    logic [9:0]       head;

    // Bytes the keyboard sends as device responses rather than key codes.
    function automatic logic is_ctl(input logic [7:0] b);
        logic hit;
        case (b)
            8'hFA, 8'hFE, 8'hEE, 8'hAA, 8'hFC, 8'h00, 8'hFF: hit = 1'b1;
            default:                                          hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Decode the incoming byte against the current prefix state.
    always_comb begin
        next_state = state;
        next_skip  = skip_cnt;
        push_req   = 1'b0;
        push_code  = rcv_data;
        push_ext   = 1'b0;
        push_brk   = 1'b0;
        ctl_hit    = 1'b0;
        if (rcv_vld) begin
            if (rcv_parity_err) begin
                next_state = IDLE;
                next_skip  = 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rcv_data == 8'hE0) begin
                            next_state = EXT;
                        end else if (rcv_data == 8'hF0) begin
                            next_state = BRK;
                        end else if (rcv_data == 8'hE1) begin
                            next_state = PAUSE;
                            next_skip  = PAUSE_SKIP;
                        end else if (is_ctl(rcv_data)) begin
                            ctl_hit = 1'b1;
                        end else begin
                            push_req = 1'b1;
                        end
                    end
                    EXT: begin
                        if (rcv_data == 8'hF0) begin
                            next_state = EXT_BRK;
                        end else if (rcv_data != 8'hE0) begin
                            push_req   = 1'b1;
                            push_ext   = 1'b1;
                            next_state = IDLE;
                        end
                    end
                    BRK: begin
                        next_state = IDLE;
                        if (rcv_data != 8'hF0 && rcv_data != 8'hE0) begin
                            push_req = 1'b1;
                            push_brk = 1'b1;
                        end
                    end
                    EXT_BRK: begin
                        next_state = IDLE;
                        if (rcv_data != 8'hF0 && rcv_data != 8'hE0) begin
                            push_req = 1'b1;
                            push_ext = 1'b1;
                            push_brk = 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (skip_cnt <= 3'd1) begin
                            push_req   = 1'b1;
                            push_code  = 8'h77;
                            push_ext   = 1'b1;
                            next_skip  = 3'd0;
                            next_state = IDLE;
                        end else begin
                            next_skip = skip_cnt - 3'd1;
                        end
                    end
                    default: begin
                        next_state = IDLE;
                        next_skip  = 3'd0;
                    end
                endcase
            end
        end
    end

    // Prefix state machine with registered control-byte pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            skip_cnt <= 3'd0;
            ctl_vld  <= 1'b0;
            ctl_byte <= 8'h00;
        end else begin
            state    <= next_state;
            skip_cnt <= next_skip;
            ctl_vld  <= ctl_hit;
            if (ctl_hit) begin
                ctl_byte <= rcv_data;
            end
        end
    end

    assign full    = (count == FULL_CNT);
    assign evt_vld = (count != '0);
    assign pop     = evt_vld & evt_rdy;
    assign do_push = push_req & (~full | pop);
    assign head    = mem[rd_ptr];

    // Head outputs are forced to zero while the FIFO is empty so stale
    // entries never leak out and the reset value is clean.
    assign evt_code = evt_vld ? head[7:0] : 8'h00;
    assign evt_brk  = evt_vld ? head[8]   : 1'b0;
    assign evt_ext  = evt_vld ? head[9]   : 1'b0;

    // Event storage write; contents need no reset as occupancy guards reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {push_ext, push_brk, push_code};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag and saturating parity-error counter; clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf     <= 1'b0;
            err_cnt <= 8'h00;
        end else if (clr) begin
            ovf     <= 1'b0;
            err_cnt <= 8'h00;
        end else begin
            if (push_req && full && !pop) begin
                ovf <= 1'b1;
            end
            if (rcv_vld && rcv_parity_err && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Testbench for ps2_key_decoder: directed vector table, hand-written corner
// sequences (overflow, saturation, async reset) and a randomized run checked
// against a prefix-list reference model.
module tb_ps2_key_decoder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rcv_data;
    logic       rcv_vld;
    logic       rcv_parity_err;
    logic       evt_vld;
    logic       evt_rdy;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;
    logic       ctl_vld;
    logic [7:0] ctl_byte;
    logic [7:0] err_cnt;
    logic       ovf;
    logic       clr;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    typedef struct {
        logic       vld;
        logic [7:0] data;
        logic       perr;
        logic       rdy;
        logic       clr;
        logic       exp_vld;
        logic [7:0] exp_code;
        logic       exp_ext;
        logic       exp_brk;
        logic       exp_ctl;
        logic [7:0] exp_ctl_byte;
        logic [7:0] exp_err;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: pending prefix bytes, event queue, flags.
    logic [7:0] pend[$];
    ev_t        mq[$];
    logic       m_ovf;
    int         m_err;
    logic       m_ctl_vld;
    logic [7:0] m_ctl_byte;

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .rcv_data       (rcv_data),
        .rcv_vld        (rcv_vld),
        .rcv_parity_err (rcv_parity_err),
        .evt_vld        (evt_vld),
        .evt_rdy        (evt_rdy),
        .evt_code       (evt_code),
        .evt_ext        (evt_ext),
        .evt_brk        (evt_brk),
        .ctl_vld        (ctl_vld),
        .ctl_byte       (ctl_byte),
        .err_cnt        (err_cnt),
        .ovf            (ovf),
        .clr            (clr)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    function automatic logic isCtl(input logic [7:0] b);
        return (b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'hAA ||
                b == 8'hFC || b == 8'h00 || b == 8'hFF);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic modelReset();
        pend.delete();
        mq.delete();
        m_ovf      = 1'b0;
        m_err      = 0;
        m_ctl_vld  = 1'b0;
        m_ctl_byte = 8'h00;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic modelStep();
        logic push = 1'b0;
        logic ctl  = 1'b0;
        logic has_e0 = 1'b0;
        logic has_f0 = 1'b0;
        logic pop_ok;
        ev_t  pe;
        pe = '0;
        if (rcv_vld) begin
            if (rcv_parity_err) begin
                pend.delete();
                if (m_err < 255) m_err++;
            end else if (pend.size() > 0 && pend[0] == 8'hE1) begin
                pend.push_back(rcv_data);
                if (pend.size() == 8) begin
                    push = 1'b1;
                    pe.code = 8'h77; pe.ext = 1'b1; pe.brk = 1'b0;
                    pend.delete();
                end
            end else begin
                foreach (pend[k]) begin
                    if (pend[k] == 8'hE0) has_e0 = 1'b1;
                    if (pend[k] == 8'hF0) has_f0 = 1'b1;
                end
                if (rcv_data == 8'hE0) begin
                    if (has_f0) pend.delete();
                    else if (!has_e0) pend.push_back(8'hE0);
                end else if (rcv_data == 8'hF0) begin
                    if (has_f0) pend.delete();
                    else pend.push_back(8'hF0);
                end else if (pend.size() == 0 && rcv_data == 8'hE1) begin
                    pend.push_back(8'hE1);
                end else if (pend.size() == 0 && isCtl(rcv_data)) begin
                    ctl = 1'b1;
                end else begin
                    push = 1'b1;
                    pe.code = rcv_data; pe.ext = has_e0; pe.brk = has_f0;
                    pend.delete();
                end
            end
        end
        pop_ok = (mq.size() > 0) && evt_rdy;
        if (push && mq.size() == DEPTH && !pop_ok) m_ovf = 1'b1;
        if (pop_ok) void'(mq.pop_front());
        if (push && mq.size() < DEPTH) mq.push_back(pe);
        if (clr) begin
            m_ovf = 1'b0;
            m_err = 0;
        end
        m_ctl_vld = ctl;
        if (ctl) m_ctl_byte = rcv_data;
    endtask

    // Drive one cycle of inputs at the falling edge, return at the next one.
    task automatic applyStimulus(input logic vld, input logic [7:0] data,
                                 input logic perr, input logic rdy, input logic clr_i);
        rcv_vld        = vld;
        rcv_data       = data;
        rcv_parity_err = perr;
        evt_rdy        = rdy;
        clr            = clr_i;
        modelStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic addVec(input logic vld, input logic [7:0] data, input logic perr,
                          input logic rdy, input logic clr_i, input logic e_vld,
                          input logic [7:0] e_code, input logic e_ext, input logic e_brk,
                          input logic e_ctl, input logic [7:0] e_ctl_byte,
                          input logic [7:0] e_err);
        vec_t v;
        v.vld = vld; v.data = data; v.perr = perr; v.rdy = rdy; v.clr = clr_i;
        v.exp_vld = e_vld; v.exp_code = e_code; v.exp_ext = e_ext; v.exp_brk = e_brk;
        v.exp_ctl = e_ctl; v.exp_ctl_byte = e_ctl_byte; v.exp_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic compareModel();
        checkOutput("rnd_evt_vld", evt_vld, mq.size() > 0);
        if (mq.size() > 0)
            checkOutput("rnd_head", {evt_code, evt_ext, evt_brk},
                        {mq[0].code, mq[0].ext, mq[0].brk});
        checkOutput("rnd_ctl_vld", ctl_vld, m_ctl_vld);
        if (m_ctl_vld) checkOutput("rnd_ctl_byte", ctl_byte, m_ctl_byte);
        checkOutput("rnd_err_cnt", err_cnt, m_err);
        checkOutput("rnd_ovf", ovf, m_ovf);
    endtask

    initial begin
        logic [7:0] drain_codes [4];
        logic [7:0] b;
        logic [7:0] ctl_set [7];

        rst = 1'b1; rcv_vld = 1'b0; rcv_data = 8'h00; rcv_parity_err = 1'b0;
        evt_rdy = 1'b0; clr = 1'b0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_evt_vld", evt_vld, 0);
        checkOutput("reset_evt_code", evt_code, 0);
        checkOutput("reset_ctl_vld", ctl_vld, 0);
        checkOutput("reset_ctl_byte", ctl_byte, 0);
        checkOutput("reset_err_cnt", err_cnt, 0);
        checkOutput("reset_ovf", ovf, 0);
        rst = 1'b0;
        @(negedge clk);

        //      vld data  perr rdy clr | vld code  ext brk ctl cbyte err
        addVec(1, 8'h1C, 0, 0, 0,   1, 8'h1C, 0, 0,  0, 8'h00, 0);
        addVec(1, 8'hF0, 0, 1, 0,   0, 8'h00, 0, 0,  0, 8'h00, 0);
        addVec(1, 8'h1C, 0, 0, 0,   1, 8'h1C, 0, 1,  0, 8'h00, 0);
        addVec(1, 8'hE0, 0, 1, 0,   0, 8'h00, 0, 0,  0, 8'h00, 0);
        addVec(1, 8'h75, 0, 0, 0,   1, 8'h75, 1, 0,  0, 8'h00, 0);
        addVec(1, 8'hE0, 0, 1, 0,   0, 8'h00, 0, 0,  0, 8'h00, 0);
        addVec(1, 8'hF0, 0, 0, 0,   0, 8'h00, 0, 0,  0, 8'h00, 0);
        addVec(1, 8'h75, 0, 0, 0,   1, 8'h75, 1, 1,  0, 8'h00, 0);
        addVec(0, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0,  0, 8'h00, 0);
        addVec(1, 8'hE1, 0, 0, 0,   0, 8'h00, 0, 0,  0, 8'h00, 0);
        addVec(1, 8'h14, 0, 0, 0,   0, 8'h00, 0, 0,  0, 8'h00, 0);
        addVec(1, 8'h77, 0, 0, 0,   0, 8'h00, 0, 0,  0, 8'h00, 0);
        addVec(1, 8'hE1, 0, 0, 0,   0, 8'h00, 0, 0,  0, 8'h00, 0);
        addVec(1, 8'hF0, 0, 0, 0,   0, 8'h00, 0, 0,  0, 8'h00, 0);
        addVec(1, 8'h14, 0, 0, 0,   0, 8'h00, 0, 0,  0, 8'h00, 0);
        addVec(1, 8'hF0, 0, 0, 0,   0, 8'h00, 0, 0,  0, 8'h00, 0);
        addVec(1, 8'h77, 0, 0, 0,   1, 8'h77, 1, 0,  0, 8'h00, 0);
        addVec(1, 8'h1C, 0, 1, 0,   1, 8'h1C, 0, 0,  0, 8'h00, 0);
        addVec(1, 8'hFA, 0, 1, 0,   0, 8'h00, 0, 0,  1, 8'hFA, 0);
        addVec(0, 8'h00, 0, 0, 0,   0, 8'h00, 0, 0,  0, 8'h00, 0);
        addVec(1, 8'hE0, 1, 0, 0,   0, 8'h00, 0, 0,  0, 8'h00, 1);
        addVec(1, 8'h1C, 0, 0, 0,   1, 8'h1C, 0, 0,  0, 8'h00, 1);
        addVec(0, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0,  0, 8'h00, 1);
        addVec(1, 8'h1C, 1, 0, 1,   0, 8'h00, 0, 0,  0, 8'h00, 0);
        addVec(1, 8'h00, 0, 0, 0,   0, 8'h00, 0, 0,  1, 8'h00, 0);
        addVec(1, 8'hE0, 0, 0, 0,   0, 8'h00, 0, 0,  0, 8'h00, 0);
        addVec(1, 8'hFA, 0, 0, 0,   1, 8'hFA, 1, 0,  0, 8'h00, 0);
        addVec(0, 8'h00, 0, 1, 0,   0, 8'h00, 0, 0,  0, 8'h00, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].vld, vecs[i].data, vecs[i].perr, vecs[i].rdy, vecs[i].clr);
            checkOutput($sformatf("vec%0d_evt_vld", i), evt_vld, vecs[i].exp_vld);
            if (vecs[i].exp_vld)
                checkOutput($sformatf("vec%0d_head", i), {evt_code, evt_ext, evt_brk},
                            {vecs[i].exp_code, vecs[i].exp_ext, vecs[i].exp_brk});
            checkOutput($sformatf("vec%0d_ctl_vld", i), ctl_vld, vecs[i].exp_ctl);
            if (vecs[i].exp_ctl)
                checkOutput($sformatf("vec%0d_ctl_byte", i), ctl_byte, vecs[i].exp_ctl_byte);
            checkOutput($sformatf("vec%0d_err_cnt", i), err_cnt, vecs[i].exp_err);
        end

        // Overflow: five makes into a four-deep FIFO with no consumer.
        checkOutput("ovf_before", ovf, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 8'h11 + 8'(i), 0, 0, 0);
        checkOutput("ovf_set", ovf, 1);
        checkOutput("ovf_head", evt_code, 8'h11);
        // Push and pop together while full.
        applyStimulus(1, 8'h16, 0, 1, 0);
        drain_codes[0] = 8'h12; drain_codes[1] = 8'h13;
        drain_codes[2] = 8'h14; drain_codes[3] = 8'h16;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain%0d_vld", i), evt_vld, 1);
            checkOutput($sformatf("drain%0d_code", i), evt_code, drain_codes[i]);
            applyStimulus(0, 8'h00, 0, 1, 0);
        end
        checkOutput("drain_empty", evt_vld, 0);
        checkOutput("ovf_sticky", ovf, 1);
        applyStimulus(0, 8'h00, 0, 0, 1);
        checkOutput("ovf_cleared", ovf, 0);

        // Saturation of the parity-error counter.
        for (int i = 0; i < 256; i++) applyStimulus(1, 8'h1C, 1, 0, 0);
        checkOutput("err_saturated", err_cnt, 8'hFF);

        // Async reset mid-prefix with non-zero outputs.
        applyStimulus(1, 8'h1C, 0, 0, 0);
        applyStimulus(1, 8'hAA, 0, 0, 0);
        applyStimulus(1, 8'hE0, 0, 0, 0);
        applyStimulus(1, 8'hF0, 0, 0, 0);
        checkOutput("pre_reset_evt_vld", evt_vld, 1);
        rcv_vld = 1'b0;
        #2 rst = 1'b1;
        modelReset();
        #1;
        checkOutput("async_evt_vld", evt_vld, 0);
        checkOutput("async_evt_fields", {evt_code, evt_ext, evt_brk}, 0);
        checkOutput("async_ctl", {ctl_vld, ctl_byte}, 0);
        checkOutput("async_err_cnt", err_cnt, 0);
        checkOutput("async_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 8'h1C, 0, 0, 0);
        checkOutput("post_reset_vld", evt_vld, 1);
        checkOutput("post_reset_head", {evt_code, evt_ext, evt_brk}, {8'h1C, 1'b0, 1'b0});
        applyStimulus(0, 8'h00, 0, 1, 0);

        // Randomized run against the reference model.
        ctl_set[0] = 8'hFA; ctl_set[1] = 8'hFE; ctl_set[2] = 8'hEE; ctl_set[3] = 8'hAA;
        ctl_set[4] = 8'hFC; ctl_set[5] = 8'h00; ctl_set[6] = 8'hFF;
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = 8'hE1;
                5:       b = ctl_set[$urandom_range(0, 6)];
                default: b = 8'($urandom_range(0, 255));
            endcase
            applyStimulus($urandom_range(0, 3) != 0, b, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 63) == 0);
            compareModel();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
